rcosc_baud_tick_gen: RTL

//  Consumes the global 160 MHz RC-oscillator clock (RCOSC_160MHZ_GL) and generates UART timing for the UART-to-SPI bridge.

---
 rtl/rcosc_baud_pkg.sv | 18 +
 rtl/rcosc_settle_cnt.sv | 39 +++
 rtl/rcosc_baud_tick_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/rcosc_baud_pkg.sv
// Shared constants and types for the RC-oscillator baud tick generator.
// Increments are round(baud*OSR*2^ACC_W/160e6).
package rcosc_baud_pkg;

  localparam int ACC_W = 24;
  localparam int OSR   = 16;
  localparam int OS_W  = $clog2(OSR);

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [OS_W-1:0]  os_cnt_t;

  localparam acc_t    INCR_115200 = 24'h02F2FA;
  localparam acc_t    INCR_9600   = 24'h003EEA;
  localparam acc_t    INCR_RST    = INCR_115200;
  localparam os_cnt_t OS_LAST     = os_cnt_t'(OSR - 1);
  localparam os_cnt_t OS_MID      = os_cnt_t'(OSR / 2);

endpackage

// File: rtl/rcosc_settle_cnt.sv
// Post-reset oscillator settle hold-off: ready_o rises on the SETTLE_CYCLES-th
// clock after reset release and stays high until the next reset.
module rcosc_settle_cnt #(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic ready_o
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (!ready_q) begin
      // Counter parks on LAST once ready; no wrap needed.
      if (cnt_q == LAST) ready_d = 1'b1;
      else               cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/rcosc_baud_tick_gen.sv
// Fractional-accumulator UART tick generator (16x and 1x enables) on the 160 MHz RC clock.
// Define RCOSC_BAUD_SYNC_EN to add the SYNC port that realigns the bit phase to mid-bit.
module rcosc_baud_tick_gen
  import rcosc_baud_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic             RCOSC_160MHZ_GL,
  input  logic             RESET,
  input  logic             CFG_VALID,
  input  logic [ACC_W-1:0] CFG_INCR,
  output logic             CFG_READY,
  output logic             READY,
  output logic             TICK_16X,
  output logic             TICK_1X
`ifdef RCOSC_BAUD_SYNC_EN
  ,
  input  logic             SYNC
`endif
);

  logic       ready;
  logic       cfg_fire;
  logic       carry;
  logic [ACC_W:0] sum;

  acc_t    acc_q,  acc_d;
  acc_t    incr_q, incr_d;
  os_cnt_t os_q,   os_d;
  logic    tick16_q, tick16_d;
  logic    tick1_q,  tick1_d;

  rcosc_settle_cnt #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk_i   (RCOSC_160MHZ_GL),
    .rst_i   (RESET),
    .ready_o (ready)
  );

  assign sum      = {1'b0, acc_q} + {1'b0, incr_q};
  assign carry    = sum[ACC_W];
  assign cfg_fire = CFG_VALID & ready;

  always_comb begin
    acc_d    = '0;
    os_d     = '0;
    incr_d   = incr_q;
    tick16_d = 1'b0;
    tick1_d  = 1'b0;
    if (ready) begin
      // The carry of this cycle's add still ticks even if the phase is reset below.
      tick16_d = carry;
      tick1_d  = carry && (os_q == OS_LAST);
      acc_d    = sum[ACC_W-1:0];
      os_d     = os_q;
      if (carry) os_d = (os_q == OS_LAST) ? '0 : os_q + os_cnt_t'(1);
      if (cfg_fire) begin
        incr_d = CFG_INCR;
        acc_d  = '0;
        os_d   = '0;
      end
`ifdef RCOSC_BAUD_SYNC_EN
      if (SYNC) begin
        acc_d = '0;
        os_d  = OS_MID;
      end
`endif
    end
  end

  always_ff @(posedge RCOSC_160MHZ_GL) begin
    if (RESET) begin
      acc_q    <= '0;
      os_q     <= '0;
      incr_q   <= INCR_RST;
      tick16_q <= 1'b0;
      tick1_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      os_q     <= os_d;
      incr_q   <= incr_d;
      tick16_q <= tick16_d;
      tick1_q  <= tick1_d;
    end
  end

  assign READY     = ready;
  assign CFG_READY = ready;
  assign TICK_16X  = tick16_q;
  assign TICK_1X   = tick1_q;

endmodule
